huff_min_queue: RTL
===================

HUFF_MIN_QUEUE -- requirements
Module: huff_min_queue

Interface
REQ-001 Parameter W, default 4, width of one node weight; it matches the adder operand/sum width.
REQ-002 Parameter DEPTH, default 8, maximum number of queued weights.
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 START  input  1  one-cycle pulse; clears the queue and returns to LOAD.
REQ-006 LOAD_VALID  input  1  LOAD_DATA is a leaf weight to insert.
REQ-007 LOAD_DATA  input  W  leaf weight (symbol frequency).
REQ-008 LOAD_LAST  input  1  qualifies LOAD_VALID; marks the final leaf.
REQ-009 LOAD_READY  output  1  high in LOAD while count < DEPTH.
REQ-010 MIN_1  output  W  smallest popped weight; drives adder ADD_1.
REQ-011 MIN_2  output  W  second-smallest popped weight; drives adder ADD_2.
REQ-012 PAIR_VALID  output  1  one-cycle pulse; MIN_1/MIN_2 are a new pair.
REQ-013 SUM_VALID  input  1  SUM_IN is the adder result to re-insert.
REQ-014 SUM_IN  input  W  adder SUM.
REQ-015 COUNT  output  clog2(DEPTH+1)  current number of entries.
REQ-016 DONE  output  1  tree reduction complete; held until START or RST.
REQ-017 ROOT  output  W  final remaining weight; valid while DONE.
REQ-018 ERR  output  1  sticky error flag.

Function
REQ-019 The queue SHALL keep entries sorted ascending, entry[0] smallest; each insert is a one-cycle shift-insert.
REQ-020 Equal weights SHALL be ordered by arrival: a new entry goes after existing equal entries.
REQ-021 The FSM SHALL have states LOAD, MERGE, WAIT_SUM and DONE.
REQ-022 LOAD: each accepted LOAD_VALID inserts LOAD_DATA, with COUNT updated next cycle.
REQ-023 LOAD with LOAD_LAST accepted: next state is MERGE.
REQ-024 LOAD_VALID while count == DEPTH SHALL be dropped and set ERR.
REQ-025 LOAD_LAST with the queue empty and no valid data SHALL set ERR and stay in LOAD.
REQ-026 MERGE with count >= 2: in one cycle, pop entry[0] into MIN_1 and entry[1] into MIN_2 (registered outputs), pulse PAIR_VALID for one cycle, decrement COUNT by 2, and go to WAIT_SUM.
REQ-027 MERGE with count == 1: go to DONE; ROOT = entry[0]; DONE = 1.
REQ-028 WAIT_SUM: on SUM_VALID, insert SUM_IN and return to MERGE.
REQ-029 Pair-to-next-pair spacing SHALL be at least 3 cycles with a 1-cycle adder.
REQ-030 SUM_VALID outside WAIT_SUM SHALL be ignored without setting ERR.
REQ-031 LOAD_VALID outside LOAD SHALL be ignored and set ERR.
REQ-032 START in any state SHALL take priority over all other inputs: COUNT becomes 0, DONE and ERR become 0, and the next state is LOAD.
REQ-033 MIN_1 and MIN_2 SHALL hold their values between pairs.
REQ-034 No arithmetic is performed in this block; weights pass through unmodified at W bits.

Reset
REQ-035 RST SHALL immediately force:
- state LOAD;
- COUNT 0, and all entries 0;
- MIN_1, MIN_2 and ROOT 0;
- PAIR_VALID, DONE and ERR 0.
REQ-036 RST asserted mid-merge SHALL discard any pending pair or sum; no PAIR_VALID is issued after RST deasserts until a new load completes.

Configuration
REQ-037 Macro HUFF_MIN_QUEUE_STATS_EN.
- Defined: add output MERGE_CNT, clog2(DEPTH) bits, reset to 0, cleared by START, incremented on each PAIR_VALID.
- Undefined: the MERGE_CNT port and its counter are absent; all other behaviour is identical.

Structure
REQ-038 Shared package huff_pkg SHALL hold the W and DEPTH defaults, the FSM state encoding, and the weight type.
REQ-039 One sub-module, huff_sort_cell, SHALL implement one queue slot with its compare/shift/hold logic, instantiated DEPTH times.

Verification
REQ-040 RST, load 3, 1, 2 (2 with LAST) -> first PAIR_VALID with MIN_1=1, MIN_2=2, COUNT=1.
REQ-041 Full run on 1, 2, 3 with a 1-cycle adder model -> pairs (1,2), then (3,3); DONE=1, ROOT=6, COUNT=1.
REQ-042 Load 9 leaves with DEPTH=8 -> 9th dropped, LOAD_READY low at COUNT=8, ERR=1.
REQ-043 Load 5, 5, 7 -> first pair (5,5); SUM 10 inserted after 7; second pair (7,10).
REQ-044 RST asserted in WAIT_SUM -> all outputs 0 immediately; late SUM_VALID ignored; state LOAD.
REQ-045 Single leaf 4 with LAST -> no PAIR_VALID; DONE=1, ROOT=4; START then clears DONE.

Source files
------------

// File: rtl/huff_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : huff_pkg                                                  |
// | Purpose  : Shared defaults, FSM encoding and weight type for the     |
// |            Huffman min-queue.                                        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package huff_pkg;

  localparam int unsigned c_w_default     = 4;
  localparam int unsigned c_depth_default = 8;

  typedef enum logic [1:0] {
    ST_LOAD     = 2'd0,
    ST_MERGE    = 2'd1,
    ST_WAIT_SUM = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  typedef logic [c_w_default-1:0] weight_t;

endpackage
`default_nettype wire

// File: rtl/huff_sort_cell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : huff_sort_cell                                            |
// | Purpose  : One slot of the sorted queue: holds, shift-inserts or     |
// |            shifts down by two on a pop.                              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module huff_sort_cell
  import huff_pkg::*;
#(
  parameter int W = c_w_default
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_ins,
  input  logic         i_pop,
  input  logic         i_occupied,
  input  logic         i_le_prev,
  input  logic [W-1:0] i_ins_data,
  input  logic [W-1:0] i_prev_data,
  input  logic [W-1:0] i_next2_data,
  output logic [W-1:0] o_data,
  output logic         o_le
);

  logic [W-1:0] r_data;
  logic         w_le;

  // "<=" keeps equal weights ahead of a newcomer, giving arrival order on ties
  assign w_le   = i_occupied && (r_data <= i_ins_data);
  assign o_le   = w_le;
  assign o_data = r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_clr) begin
      r_data <= '0;
    end else if (i_ins) begin
      if (!w_le) begin
        r_data <= i_le_prev ? i_ins_data : i_prev_data;
      end
    end else if (i_pop) begin
      r_data <= i_next2_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/huff_min_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : huff_min_queue                                            |
// | Purpose  : Sorted min-queue feeding an external adder for Huffman    |
// |            tree reduction. Optional HUFF_MIN_QUEUE_STATS_EN adds a   |
// |            merge_cnt output counting issued pairs.                   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module huff_min_queue
  import huff_pkg::*;
#(
  parameter int W     = c_w_default,
  parameter int DEPTH = c_depth_default
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       load_valid,
  input  logic [W-1:0]               load_data,
  input  logic                       load_last,
  output logic                       load_ready,
  output logic [W-1:0]               min_1,
  output logic [W-1:0]               min_2,
  output logic                       pair_valid,
  input  logic                       sum_valid,
  input  logic [W-1:0]               sum_in,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       done,
  output logic [W-1:0]               root,
  output logic                       err
`ifdef HUFF_MIN_QUEUE_STATS_EN
  ,
  output logic [$clog2(DEPTH)-1:0]   merge_cnt
`endif
);

  localparam int c_cnt_w = $clog2(DEPTH+1);
  localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_two       = c_cnt_w'(2);

  state_t             r_state;
  logic [c_cnt_w-1:0] r_count;
  logic [W-1:0]       r_min_1;
  logic [W-1:0]       r_min_2;
  logic [W-1:0]       r_root;
  logic               r_pair_valid;
  logic               r_done;
  logic               r_err;

  logic               w_ins;
  logic               w_pop;
  logic [W-1:0]       w_ins_data;
  logic               w_not_full;
  logic [W-1:0]       w_data [DEPTH];
  logic [DEPTH-1:0]   w_le;

  assign w_not_full = (r_count < c_depth_cnt);

  always_comb begin
    w_ins      = 1'b0;
    w_pop      = 1'b0;
    w_ins_data = load_data;
    if (!start) begin
      case (r_state)
        ST_LOAD:     w_ins = load_valid && w_not_full;
        ST_MERGE:    w_pop = (r_count >= c_two);
        ST_WAIT_SUM: begin
          w_ins      = sum_valid;
          w_ins_data = sum_in;
        end
        default: ;
      endcase
    end
  end

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
      logic         w_le_prev;
      logic [W-1:0] w_prev;
      logic [W-1:0] w_next2;

      if (i == 0) begin : g_head
        assign w_le_prev = 1'b1;
        assign w_prev    = '0;
      end else begin : g_body
        assign w_le_prev = w_le[i-1];
        assign w_prev    = w_data[i-1];
      end

      if (i + 2 < DEPTH) begin : g_next
        assign w_next2 = w_data[i+2];
      end else begin : g_tail
        assign w_next2 = '0;
      end

      huff_sort_cell #(
        .W (W)
      ) u_cell (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (start),
        .i_ins        (w_ins),
        .i_pop        (w_pop),
        .i_occupied   (32'(r_count) > i),
        .i_le_prev    (w_le_prev),
        .i_ins_data   (w_ins_data),
        .i_prev_data  (w_prev),
        .i_next2_data (w_next2),
        .o_data       (w_data[i]),
        .o_le         (w_le[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_LOAD;
      r_count      <= '0;
      r_min_1      <= '0;
      r_min_2      <= '0;
      r_root       <= '0;
      r_pair_valid <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_pair_valid <= 1'b0;
      if (start) begin
        r_state <= ST_LOAD;
        r_count <= '0;
        r_done  <= 1'b0;
        r_err   <= 1'b0;
      end else begin
        case (r_state)
          ST_LOAD: begin
            if (load_valid) begin
              if (w_not_full) begin
                r_count <= r_count + c_one;
                if (load_last) begin
                  r_state <= ST_MERGE;
                end
              end else begin
                r_err <= 1'b1;
              end
            end else if (load_last && (r_count == '0)) begin
              r_err <= 1'b1;
            end
          end
          ST_MERGE: begin
            if (r_count >= c_two) begin
              r_min_1      <= w_data[0];
              r_min_2      <= w_data[1];
              r_pair_valid <= 1'b1;
              r_count      <= r_count - c_two;
              r_state      <= ST_WAIT_SUM;
            end else begin
              r_root  <= w_data[0];
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
          ST_WAIT_SUM: begin
            if (sum_valid) begin
              r_count <= r_count + c_one;
              r_state <= ST_MERGE;
            end
          end
          default: r_done <= 1'b1;
        endcase
        // leaves offered after loading has finished are a protocol violation
        if (load_valid && (r_state != ST_LOAD)) begin
          r_err <= 1'b1;
        end
      end
    end
  end

`ifdef HUFF_MIN_QUEUE_STATS_EN
  logic [$clog2(DEPTH)-1:0] r_merge_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_merge_cnt <= '0;
    end else if (start) begin
      r_merge_cnt <= '0;
    end else if (w_pop) begin
      r_merge_cnt <= r_merge_cnt + 1'b1;
    end
  end

  assign merge_cnt = r_merge_cnt;
`endif

  assign load_ready = (r_state == ST_LOAD) && w_not_full;
  assign min_1      = r_min_1;
  assign min_2      = r_min_2;
  assign pair_valid = r_pair_valid;
  assign count      = r_count;
  assign done       = r_done;
  assign root       = r_root;
  assign err        = r_err;

endmodule
`default_nettype wire
